// File: rtl/skip_slice_sequencer_pkg.sv
// skip_seq_pkg: shared FSM state type plus width and group-count helpers for the skip slice sequencer
package skip_seq_pkg;
  typedef enum logic {IDLE, STREAM} state_e;
  function automatic int clog2m1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int num_groups(input int total_ch, input int group_ch);
    return total_ch / group_ch;
  endfunction
endpackage

// File: rtl/skip_slice_sequencer_if.sv
// skip_slice_sequencer_if: load handshake (in_valid/in_ready/in_skip) and slice stream (out_valid/out_ready/out_skip/out_group/out_pass/out_last); slave = sequencer side
interface skip_slice_sequencer_if #(
  parameter int DATA_W   = 16,
  parameter int TOTAL_CH = 16,
  parameter int GROUP_CH = 4,
  parameter int PASSES   = 2
);
  localparam int GW = skip_seq_pkg::clog2m1(skip_seq_pkg::num_groups(TOTAL_CH, GROUP_CH));
  localparam int PW = skip_seq_pkg::clog2m1(PASSES);
  logic                         in_valid;
  logic                         in_ready;
  logic [TOTAL_CH*DATA_W-1:0]   in_skip;
  logic                         out_valid;
  logic                         out_ready;
  logic [GROUP_CH*DATA_W-1:0]   out_skip;
  logic [GW-1:0]                out_group;
  logic [PW-1:0]                out_pass;
  logic                         out_last;
  modport master (
    output in_valid, in_skip, out_ready,
    input  in_ready, out_valid, out_skip, out_group, out_pass, out_last
  );
  modport slave (
    input  in_valid, in_skip, out_ready,
    output in_ready, out_valid, out_skip, out_group, out_pass, out_last
  );
endinterface

// File: rtl/skip_slice_sequencer_group_mux.sv
// skip_group_mux: combinational slice select; vec_i (TOTAL_CH*DATA_W) + grp_i (GW) -> slice_o (GROUP_CH*DATA_W), group g = channels g*GROUP_CH..
module skip_group_mux #(
  parameter int DATA_W   = 16,
  parameter int TOTAL_CH = 16,
  parameter int GROUP_CH = 4,
  parameter int GW       = 2
) (
  input  logic [TOTAL_CH*DATA_W-1:0] vec_i,
  input  logic [GW-1:0]              grp_i,
  output logic [GROUP_CH*DATA_W-1:0] slice_o
);
  localparam int SW = GROUP_CH * DATA_W;
  assign slice_o = SW'(vec_i >> (int'(grp_i) * SW));
endmodule

// File: rtl/skip_slice_sequencer.sv
// skip_slice_sequencer: latches one skip vector and replays it as GROUP_CH-channel slices PASSES times; ports clk, rst (sync active-high), skip_io (slave modport)
module skip_slice_sequencer
  import skip_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int TOTAL_CH = 16,
  parameter int GROUP_CH = 4,
  parameter int PASSES   = 2
) (
  input logic                    clk,
  input logic                    rst,
  skip_slice_sequencer_if.slave  skip_io
);
  localparam int NG = num_groups(TOTAL_CH, GROUP_CH);
  localparam int GW = clog2m1(NG);
  localparam int PW = clog2m1(PASSES);
  generate
    if (TOTAL_CH % GROUP_CH != 0 || PASSES < 1) begin : g_bad_params
      $error("skip_slice_sequencer: TOTAL_CH must be a multiple of GROUP_CH and PASSES >= 1");
    end
  endgenerate
  state_e                     state_q, state_d;
  logic [TOTAL_CH*DATA_W-1:0] vec_q, vec_d;
  logic [GW-1:0]              grp_q, grp_d;
  logic [PW-1:0]              pass_q, pass_d;
  logic                       last, fire, load, grp_wrap;
  assign grp_wrap = grp_q == GW'(NG - 1);
  assign last     = state_q == STREAM && grp_wrap && pass_q == PW'(PASSES - 1);
  assign fire     = state_q == STREAM && skip_io.out_ready;
  // Accepting the final beat frees the vector register in the same cycle, so a new load needs no bubble.
  assign skip_io.in_ready = !rst && (state_q == IDLE || (fire && last));
  assign load     = skip_io.in_valid && skip_io.in_ready;
  always_comb begin
    state_d = load ? STREAM : (fire && last) ? IDLE : state_q;
    vec_d   = load ? skip_io.in_skip : vec_q;
    grp_d   = load ? '0 : fire ? (grp_wrap ? '0 : grp_q + GW'(1)) : grp_q;
    pass_d  = load ? '0 : (fire && grp_wrap) ? (pass_q == PW'(PASSES - 1) ? '0 : pass_q + PW'(1)) : pass_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      grp_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      grp_q   <= grp_d;
      pass_q  <= pass_d;
    end
  end
  skip_group_mux #(
    .DATA_W  (DATA_W),
    .TOTAL_CH(TOTAL_CH),
    .GROUP_CH(GROUP_CH),
    .GW      (GW)
  ) u_mux (
    .vec_i  (vec_q),
    .grp_i  (grp_q),
    .slice_o(skip_io.out_skip)
  );
  assign skip_io.out_valid = state_q == STREAM;
  assign skip_io.out_group = grp_q;
  assign skip_io.out_pass  = pass_q;
  assign skip_io.out_last  = last;
endmodule

// File: tb/tb_skip_slice_sequencer.sv
// tb_skip_slice_sequencer: beat-index reference model plus directed vectors for default and single-slice configurations
module tb_skip_slice_sequencer;
  localparam int NG = 4;
  localparam int NB = 8;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  skip_slice_sequencer_if #(.DATA_W(16), .TOTAL_CH(16), .GROUP_CH(4), .PASSES(2)) a ();
  skip_slice_sequencer_if #(.DATA_W(16), .TOTAL_CH(8), .GROUP_CH(8), .PASSES(1)) b ();
  skip_slice_sequencer #(.DATA_W(16), .TOTAL_CH(16), .GROUP_CH(4), .PASSES(2)) dut_a (
    .clk(clk), .rst(rst), .skip_io(a.slave));
  skip_slice_sequencer #(.DATA_W(16), .TOTAL_CH(8), .GROUP_CH(8), .PASSES(1)) dut_b (
    .clk(clk), .rst(rst), .skip_io(b.slave));
  int pass_cnt = 0;
  int total_cnt = 0;
  bit run = 0;
  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    else pass_cnt++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [255:0] m_vec;
  bit m_act = 0;
  bit m_done;
  int m_beat = 0;
  function automatic logic [63:0] exp_slice(input logic [255:0] v, input int g);
    return 64'(v >> (g * 64));
  endfunction
  always @(posedge clk) begin
    if (rst) m_act = 0;
    else begin
      m_done = m_act && a.out_ready && m_beat == NB - 1;
      if ((!m_act || m_done) && a.in_valid) begin
        m_vec = a.in_skip;
        m_act = 1;
        m_beat = 0;
      end else if (m_done) m_act = 0;
      else if (m_act && a.out_ready) m_beat++;
    end
  end
  always @(negedge clk) begin
    if (run) begin
      chk("m_valid", a.out_valid, m_act);
      chk("m_in_ready", a.in_ready, !rst && (!m_act || (a.out_ready && m_beat == NB - 1)));
      if (m_act) begin
        chk("m_skip", a.out_skip, exp_slice(m_vec, m_beat % NG));
        chk("m_group", a.out_group, m_beat % NG);
        chk("m_pass", a.out_pass, m_beat / NG);
        chk("m_last", a.out_last, m_beat == NB - 1);
      end else chk("m_last_idle", a.out_last, 0);
    end
  end
  logic [255:0] vec_a, vec_b, vec_c;
  logic [127:0] vec_d;
  initial begin
    for (int c = 0; c < 16; c++) begin
      vec_a[c*16 +: 16] = 16'h0100 + 16'(c);
      vec_b[c*16 +: 16] = 16'h0200 + 16'(c);
      vec_c[c*16 +: 16] = 16'h0300 + 16'(c);
    end
    for (int c = 0; c < 8; c++) vec_d[c*16 +: 16] = 16'h0500 + 16'(c);
    rst = 1;
    a.in_valid = 0; a.in_skip = '0; a.out_ready = 1;
    b.in_valid = 0; b.in_skip = '0; b.out_ready = 1;
    step();
    run = 1;
    step();
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_valid", a.out_valid, 0);
    chk("rst_skip", a.out_skip, 0);
    chk("rst_group", a.out_group, 0);
    chk("rst_pass", a.out_pass, 0);
    chk("rst_last", a.out_last, 0);
    chk("rst_b_in_ready", b.in_ready, 0);
    rst = 0;
    #1;
    chk("idle_in_ready", a.in_ready, 1);
    b.in_skip = vec_d; b.in_valid = 1;
    step();
    b.in_valid = 0;
    chk("b_valid", b.out_valid, 1);
    chk("b_group", b.out_group, 0);
    chk("b_pass", b.out_pass, 0);
    chk("b_last", b.out_last, 1);
    chk("b_skip", b.out_skip, 128'h0507_0506_0505_0504_0503_0502_0501_0500);
    chk("b_in_ready", b.in_ready, 1);
    step();
    chk("b_idle", b.out_valid, 0);
    a.in_skip = vec_a; a.in_valid = 1;
    step();
    a.in_valid = 0;
    chk("first_slice", a.out_skip, 64'h0103_0102_0101_0100);
    repeat (7) step();
    chk("beat8_last", a.out_last, 1);
    chk("beat8_group", a.out_group, 3);
    chk("beat8_pass", a.out_pass, 1);
    step();
    chk("done_valid", a.out_valid, 0);
    chk("done_in_ready", a.in_ready, 1);
    a.in_valid = 1;
    step();
    a.in_valid = 0;
    step();
    a.out_ready = 0;
    step();
    chk("stall_group", a.out_group, 1);
    chk("stall_skip", a.out_skip, 64'h0107_0106_0105_0104);
    step();
    chk("stall_group2", a.out_group, 1);
    a.out_ready = 1;
    step();
    chk("resume_group", a.out_group, 2);
    repeat (6) step();
    a.in_valid = 1;
    step();
    a.in_valid = 0;
    repeat (7) step();
    a.in_skip = vec_b; a.in_valid = 1;
    #1;
    chk("b2b_in_ready", a.in_ready, 1);
    step();
    a.in_valid = 0;
    chk("b2b_valid", a.out_valid, 1);
    chk("b2b_group", a.out_group, 0);
    chk("b2b_pass", a.out_pass, 0);
    chk("b2b_skip", a.out_skip, 64'h0203_0202_0201_0200);
    step();
    step();
    a.in_skip = vec_c; a.in_valid = 1;
    #1;
    chk("busy_in_ready", a.in_ready, 0);
    step();
    step();
    a.in_valid = 0;
    chk("ignored_skip", a.out_skip, 64'h0203_0202_0201_0200);
    chk("ignored_pass", a.out_pass, 1);
    step();
    step();
    chk("pre_rst_group", a.out_group, 2);
    chk("pre_rst_pass", a.out_pass, 1);
    rst = 1;
    step();
    chk("mid_rst_valid", a.out_valid, 0);
    chk("mid_rst_skip", a.out_skip, 0);
    chk("mid_rst_group", a.out_group, 0);
    chk("mid_rst_pass", a.out_pass, 0);
    chk("mid_rst_last", a.out_last, 0);
    rst = 0;
    a.in_skip = vec_a; a.in_valid = 1;
    step();
    a.in_valid = 0;
    chk("reload_group", a.out_group, 0);
    chk("reload_pass", a.out_pass, 0);
    chk("reload_skip", a.out_skip, 64'h0103_0102_0101_0100);
    repeat (8) step();
    chk("final_idle", a.out_valid, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
